// File: rtl/rom_loader_pkg.sv
// ---------------------------------------------------------------------------
// rom_loader_pkg
// Shared types and constants for the ROM region loader that sits between the
// HPS download stream and the Green Beret core's ROM load port.
//
// Contents:
//   region_e     - index of each ROM region inside the flat download image
//   state_e      - loader FSM states
//   *_END_DEF    - default exclusive end address of each region
//   IMAGE_LEN    - required image length in bytes (end of the last region)
//   RST_HOLD_DEF - default cycles the core stays in reset after load_done
//   regionOneHot - converts a region index into its write-strobe bit
// ---------------------------------------------------------------------------
package rom_loader_pkg;

  // Regions in image order; the enum value is also the rom_we bit position.
  typedef enum logic [2:0] {
    REG_CPU = 3'd0,
    REG_CHR = 3'd1,
    REG_SPR = 3'd2,
    REG_PAL = 3'd3,
    REG_LUT = 3'd4
  } region_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  localparam int unsigned NUM_REGIONS  = 5;

  localparam int unsigned CPU_END_DEF  = 'h0C000;
  localparam int unsigned CHR_END_DEF  = 'h10000;
  localparam int unsigned SPR_END_DEF  = 'h20000;
  localparam int unsigned PAL_END_DEF  = 'h20020;
  localparam int unsigned LUT_END_DEF  = 'h20220;

  localparam int unsigned IMAGE_LEN    = LUT_END_DEF;
  localparam int unsigned RST_HOLD_DEF = 16;

  // One-hot write strobe for a region; bit order matches rom_we.
  function automatic logic [NUM_REGIONS-1:0] regionOneHot(input region_e region);
    return 5'b00001 << region;
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// ---------------------------------------------------------------------------
// rom_region_decode
// Purely combinational decode of a flat image byte address into the region it
// belongs to, the address local to that region, and an out-of-range flag for
// addresses at or beyond the end of the last region.
//
// Ports:
//   i_addr       in  25  image byte address
//   o_regionWe   out  5  one-hot region select (all zero when out of range)
//   o_localAddr  out 17  i_addr minus the region base, truncated to 17 bits
//   o_outOfRange out  1  i_addr >= LUT_END
// ---------------------------------------------------------------------------
module rom_region_decode
  import rom_loader_pkg::*;
#(
  parameter int unsigned CPU_END = CPU_END_DEF,
  parameter int unsigned CHR_END = CHR_END_DEF,
  parameter int unsigned SPR_END = SPR_END_DEF,
  parameter int unsigned PAL_END = PAL_END_DEF,
  parameter int unsigned LUT_END = LUT_END_DEF
) (
  input  logic [24:0] i_addr,
  output logic [4:0]  o_regionWe,
  output logic [16:0] o_localAddr,
  output logic        o_outOfRange
);

  localparam logic [24:0] CPU_END_A = 25'(CPU_END);
  localparam logic [24:0] CHR_END_A = 25'(CHR_END);
  localparam logic [24:0] SPR_END_A = 25'(SPR_END);
  localparam logic [24:0] PAL_END_A = 25'(PAL_END);
  localparam logic [24:0] LUT_END_A = 25'(LUT_END);

  // Region bases only matter modulo 2^17 because the local address is
  // truncated to 17 bits; subtracting the low bits gives the same result.
  localparam logic [16:0] CPU_BASE = 17'd0;
  localparam logic [16:0] CHR_BASE = 17'(CPU_END);
  localparam logic [16:0] SPR_BASE = 17'(CHR_END);
  localparam logic [16:0] PAL_BASE = 17'(SPR_END);
  localparam logic [16:0] LUT_BASE = 17'(PAL_END);

  region_e     w_region;
  logic [16:0] w_base;

  // Half-open range compare in image order; anything past the palette range
  // falls into LUT here and is then masked by the out-of-range flag.
  always_comb begin
    w_region = REG_CPU;
    w_base   = CPU_BASE;
    if (i_addr < CPU_END_A) begin
      w_region = REG_CPU;
      w_base   = CPU_BASE;
    end else if (i_addr < CHR_END_A) begin
      w_region = REG_CHR;
      w_base   = CHR_BASE;
    end else if (i_addr < SPR_END_A) begin
      w_region = REG_SPR;
      w_base   = SPR_BASE;
    end else if (i_addr < PAL_END_A) begin
      w_region = REG_PAL;
      w_base   = PAL_BASE;
    end else begin
      w_region = REG_LUT;
      w_base   = LUT_BASE;
    end
  end

  assign o_outOfRange = (i_addr >= LUT_END_A);
  assign o_localAddr  = i_addr[16:0] - w_base;
  assign o_regionWe   = o_outOfRange ? 5'b00000 : regionOneHot(w_region);

endmodule

// File: rtl/rom_region_loader.sv
// ---------------------------------------------------------------------------
// rom_region_loader
// Converts the flat HPS ROM download stream into per-region write strobes for
// the Green Beret core, verifies that bytes arrive strictly in order and that
// the image has exactly the expected length, keeps an XOR checksum, and holds
// the core in reset until a good image has been loaded.
//
// Ports:
//   clk48M      in   1  system clock
//   reset       in   1  synchronous, active-high
//   dl_active   in   1  high while the ROM download is in progress
//   dl_wr       in   1  one-cycle byte strobe
//   dl_addr     in  25  image byte address
//   dl_data     in   8  image byte
//   rom_we      out  5  one-hot region write pulse {LUT,PAL,SPR,CHR,CPU}
//   rom_addr    out 17  region-local address
//   rom_data    out  8  byte to write
//   core_reset  out  1  reset to the game core
//   load_done   out  1  image accepted
//   load_error  out  1  image rejected, sticky until the next download
//   checksum    out  8  XOR of all accepted bytes
//   byte_count  out 18  number of accepted bytes
// ---------------------------------------------------------------------------
module rom_region_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned CPU_END  = CPU_END_DEF,
  parameter int unsigned CHR_END  = CHR_END_DEF,
  parameter int unsigned SPR_END  = SPR_END_DEF,
  parameter int unsigned PAL_END  = PAL_END_DEF,
  parameter int unsigned LUT_END  = LUT_END_DEF,
  parameter int unsigned RST_HOLD = RST_HOLD_DEF
) (
  input  logic        clk48M,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic [4:0]  rom_we,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error,
  output logic [7:0]  checksum,
  output logic [17:0] byte_count
);

  localparam logic [17:0] IMAGE_LEN_C = 18'(LUT_END);
  localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD - 1);

  state_e      r_state;
  logic        r_dlActivePrev;
  logic        r_armed;
  logic [15:0] r_holdCount;
  logic [4:0]  r_romWe;
  logic [16:0] r_romAddr;
  logic [7:0]  r_romData;
  logic        r_coreReset;
  logic        r_loadDone;
  logic        r_loadError;
  logic [7:0]  r_checksum;
  logic [17:0] r_byteCount;

  logic [4:0]  w_regionWe;
  logic [16:0] w_localAddr;
  logic        w_outOfRange;
  logic        w_dlRise;
  logic        w_dlFall;
  logic        w_orderBad;
  logic        w_startLoad;

  rom_region_decode #(
    .CPU_END (CPU_END),
    .CHR_END (CHR_END),
    .SPR_END (SPR_END),
    .PAL_END (PAL_END),
    .LUT_END (LUT_END)
  ) u_decode (
    .i_addr       (dl_addr),
    .o_regionWe   (w_regionWe),
    .o_localAddr  (w_localAddr),
    .o_outOfRange (w_outOfRange)
  );

  assign w_dlRise   = dl_active & ~r_dlActivePrev;
  assign w_dlFall   = ~dl_active & r_dlActivePrev;
  assign w_orderBad = (dl_addr != {7'd0, r_byteCount});

  // A new download starts either from IDLE once armed, or on a fresh rising
  // edge of dl_active after a finished or failed load. Restarts jump straight
  // to LOAD so the first byte of the new image cannot be missed.
  assign w_startLoad = ((r_state == S_IDLE) && dl_active && r_armed) ||
                       (((r_state == S_DONE) || (r_state == S_ERROR)) && w_dlRise);

  // Loader FSM with all outputs registered. rom_we defaults to zero every
  // cycle so it can only ever be a single-cycle pulse. r_armed stays low after
  // reset until dl_active has been seen low, so a download that was in flight
  // when reset hit is not mistaken for a new one.
  always_ff @(posedge clk48M) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_dlActivePrev <= 1'b0;
      r_armed        <= 1'b0;
      r_holdCount    <= '0;
      r_romWe        <= '0;
      r_romAddr      <= '0;
      r_romData      <= '0;
      r_coreReset    <= 1'b1;
      r_loadDone     <= 1'b0;
      r_loadError    <= 1'b0;
      r_checksum     <= '0;
      r_byteCount    <= '0;
    end else begin
      r_dlActivePrev <= dl_active;
      r_romWe        <= '0;

      if (w_startLoad) begin
        r_state     <= S_LOAD;
        r_coreReset <= 1'b1;
        r_loadDone  <= 1'b0;
        r_loadError <= 1'b0;
        r_checksum  <= '0;
        r_byteCount <= '0;
        r_holdCount <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_coreReset <= 1'b1;
            r_loadDone  <= 1'b0;
            if (!dl_active) begin
              r_armed <= 1'b1;
            end
          end

          // A byte arriving together with the dl_active fall is processed
          // first; an error on that byte wins over the move to CHECK.
          S_LOAD: begin
            r_coreReset <= 1'b1;
            if (dl_wr && (w_orderBad || w_outOfRange)) begin
              r_loadError <= 1'b1;
              r_state     <= S_ERROR;
            end else begin
              if (dl_wr) begin
                r_romWe    <= w_regionWe;
                r_romAddr  <= w_localAddr;
                r_romData  <= dl_data;
                r_checksum <= r_checksum ^ dl_data;
                if (r_byteCount != '1) begin
                  r_byteCount <= r_byteCount + 18'd1;
                end
              end
              if (w_dlFall) begin
                r_state <= S_CHECK;
              end
            end
          end

          S_CHECK: begin
            if (r_byteCount == IMAGE_LEN_C) begin
              r_loadDone  <= 1'b1;
              r_holdCount <= '0;
              r_state     <= S_HOLD;
            end else begin
              r_loadError <= 1'b1;
              r_state     <= S_ERROR;
            end
          end

          // Keep the core in reset for RST_HOLD cycles after load_done rises
          // so its ROMs are settled before it starts fetching.
          S_HOLD: begin
            r_coreReset <= 1'b1;
            if (r_holdCount == HOLD_LAST) begin
              r_coreReset <= 1'b0;
              r_state     <= S_DONE;
            end else begin
              r_holdCount <= r_holdCount + 16'd1;
            end
          end

          S_DONE: begin
            r_coreReset <= 1'b0;
            r_loadDone  <= 1'b1;
          end

          S_ERROR: begin
            r_coreReset <= 1'b1;
            r_loadDone  <= 1'b0;
            r_loadError <= 1'b1;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rom_we     = r_romWe;
  assign rom_addr   = r_romAddr;
  assign rom_data   = r_romData;
  assign core_reset = r_coreReset;
  assign load_done  = r_loadDone;
  assign load_error = r_loadError;
  assign checksum   = r_checksum;
  assign byte_count = r_byteCount;

endmodule

// File: doc/rom_region_loader.md
Name: rom_region_loader

Overview:
- Sits directly upstream of the game core's ROM load port, between the HPS download stream and FPGA_GreenBeret.
- Decodes the flat ROM image into per-region write strobes with region-local addresses.
- Checks stream ordering and length, and accumulates a byte checksum.
- Holds the core in reset until a complete, well-formed image has loaded.

Parameters:
- CPU_END, 'h0C000, exclusive end of main CPU ROM region (base 0)
- CHR_END, 'h10000, exclusive end of character gfx region
- SPR_END, 'h20000, exclusive end of sprite gfx region
- PAL_END, 'h20020, exclusive end of palette PROM region
- LUT_END, 'h20220, exclusive end of colour lookup PROM region; equals required image length
- RST_HOLD, 16, clk48M cycles core_reset stays high after load_done rises

Ports:
- clk48M  in  1  system clock, 48 MHz
- reset  in  1  synchronous, active-high
- dl_active  in  1  high while ROM index 0 download is in progress
- dl_wr  in  1  one-cycle byte strobe
- dl_addr  in  25  image byte address
- dl_data  in  8  image byte
- rom_we  out  5  one-hot region write strobe: [0] CPU, [1] CHR, [2] SPR, [3] PAL, [4] LUT
- rom_addr  out  17  address local to the region (dl_addr minus region base)
- rom_data  out  8  byte to write
- core_reset  out  1  reset to the game core
- load_done  out  1  image accepted
- load_error  out  1  image rejected (sticky until next download)
- checksum  out  8  XOR of all accepted bytes
- byte_count  out  18  accepted byte count

Behaviour:
- Reset values:
  - rom_we=0, rom_addr=0, rom_data=0.
  - core_reset=1, load_done=0, load_error=0, checksum=0, byte_count=0.
  - State IDLE.
- States: IDLE, LOAD, CHECK, HOLD, DONE, ERROR.
- IDLE: on dl_active=1, clear checksum, byte_count and load_error, then go to LOAD. core_reset=1.
- LOAD: core_reset=1. On each dl_wr:
  - Ordering check: dl_addr must equal byte_count. A mismatch goes to ERROR, with no write issued for that byte.
  - Bounds check: dl_addr >= LUT_END goes to ERROR, with no write issued.
  - Otherwise the byte is accepted:
    - Exactly one rom_we bit is asserted in the following cycle (1-cycle registered latency), together with rom_addr and rom_data.
    - byte_count increments; checksum ^= dl_data.
  - Region select uses the half-open ranges [0,CPU_END), [CPU_END,CHR_END), [CHR_END,SPR_END), [SPR_END,PAL_END), [PAL_END,LUT_END).
  - rom_addr = dl_addr - region base, truncated to 17 bits.
  - rom_we is a single-cycle pulse and is never held.
  - Falling edge of dl_active (registered previous value) goes to CHECK.
- dl_wr and a dl_active fall in the same cycle: the byte is processed first, then the state moves to CHECK.
- CHECK (1 cycle): byte_count == LUT_END goes to HOLD; otherwise ERROR.
- HOLD: load_done=1, core_reset=1. A counter runs RST_HOLD cycles, then the state moves to DONE.
- DONE: core_reset=0, load_done=1. dl_write strobes are ignored.
- ERROR: load_error=1, load_done=0, core_reset=1.
  - Further dl_wr strobes are ignored while dl_active stays high.
  - After dl_active falls, stay in ERROR.
- Re-download: a rising edge of dl_active from DONE or ERROR restarts through IDLE behaviour. load_done drops and core_reset rises the same cycle the edge is seen.
- byte_count saturates at 2^18-1; it is unreachable in valid use because the bounds check fires first.
- A reset mid-load aborts immediately: strobes stop and all outputs return to reset values. A subsequent dl_active still high is not treated as a rising edge; the block waits for dl_active=0 before re-arming.
- dl_wr with dl_active=0 in IDLE/DONE: ignored, no strobe.

Decomposition:
- Shared package rom_loader_pkg holds:
  - region index enum (REG_CPU..REG_LUT);
  - state enum;
  - default region boundary constants;
  - IMAGE_LEN.
- One sub-module, rom_region_decode: combinational address-to-{region one-hot, local address, out_of_range}. The FSM, counters and output registers stay in rom_region_loader.

Test Plan:
- Full valid image: stream 0x20220 sequential bytes with data = addr[7:0].
  - rom_we pulse counts are CPU=49152, CHR=16384, SPR=65536, PAL=32, LUT=512.
  - The byte at 0x0C000 gives rom_we=5'b00010, rom_addr=0. The byte at 0x20020 gives rom_we=5'b10000, rom_addr=0.
  - load_done=1; core_reset falls exactly RST_HOLD cycles after CHECK.
  - checksum equals the precomputed XOR.
- Short image: stop at 0x2021F bytes -> load_error=1, load_done=0, core_reset stays 1.
- Out-of-order: skip address 0x100 (send 0xFF then 0x101) -> ERROR on the 0x101 strobe, no rom_we for it, later strobes ignored.
- Overrun: send a byte at 0x20220 after a full image -> load_error=1, no strobe.
- Re-download from DONE: raise dl_active -> core_reset=1 and load_done=0 in the same cycle; a second full image succeeds and checksum restarts from 0.
- Reset mid-load at byte 0x8000 with dl_active held high -> outputs at reset values, no strobes. Drop dl_active, raise it again, send a full image -> success.
